// File: rtl/sram_arb_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified SRAM.
// slave = arbiter view; master = requesters plus SRAM model.
interface sram_arb_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic [31:0] data_rdata;
  logic        data_rvalid;
  logic        stallreq_for_arb;

  modport slave (
    input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    output inst_rdata, inst_rvalid, data_rdata, data_rvalid, stallreq_for_arb
  );

  modport master (
    output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    input  inst_rdata, inst_rvalid, data_rdata, data_rvalid, stallreq_for_arb
  );
endinterface

// File: rtl/sram_arb.sv
// Fetch/data arbiter for a single-ported unified SRAM with one-cycle read return.
// Optional fetch anti-starvation override enabled by macro ARB_FAIRNESS_EN.
module sram_arb #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic      clk,
  input  logic      rst,
  sram_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RET_D = 2'd1,
    RET_I = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic        grant_inst_s;
  logic        grant_data_s;
  logic        starved_s;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;

`ifdef ARB_FAIRNESS_EN
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;

  assign starved_s = (starve_q == CW'(STARVE_LIMIT));

  // Count data wins against a waiting fetch; any fetch grant or idle fetch clears it.
  always_comb begin
    starve_d = starve_q;
    if (grant_inst_s || !bus.inst_req) begin
      starve_d = {CW{1'b0}};
    end else if (grant_data_s) begin
      starve_d = starve_q + CW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= {CW{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starved_s = 1'b0;
`endif

  // Per-cycle grant: data first unless a starved fetch is owed the slot.
  always_comb begin
    grant_inst_s = 1'b0;
    grant_data_s = 1'b0;
    if (rst) begin
      grant_inst_s = 1'b0;
      grant_data_s = 1'b0;
    end else if (bus.data_req && !(bus.inst_req && starved_s)) begin
      grant_data_s = 1'b1;
    end else if (bus.inst_req) begin
      grant_inst_s = 1'b1;
    end else begin
      grant_inst_s = 1'b0;
      grant_data_s = 1'b0;
    end
  end

  // SRAM command mux and fetch stall.
  always_comb begin
    bus.sram_en          = 1'b0;
    bus.sram_wen         = 4'h0;
    bus.sram_addr        = 32'h0000_0000;
    bus.sram_wdata       = 32'h0000_0000;
    bus.stallreq_for_arb = bus.inst_req && !grant_inst_s && !rst;
    if (grant_data_s) begin
      bus.sram_en    = 1'b1;
      bus.sram_wen   = bus.data_wen;
      bus.sram_addr  = bus.data_addr;
      bus.sram_wdata = bus.data_wdata;
    end else if (grant_inst_s) begin
      bus.sram_en    = 1'b1;
      bus.sram_wen   = 4'h0;
      bus.sram_addr  = bus.inst_addr;
      bus.sram_wdata = 32'h0000_0000;
    end else begin
      bus.sram_en    = 1'b0;
    end
  end

  // Return-state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next return state depends only on this cycle's grant; writes return nothing.
  always_comb begin
    state_d = IDLE;
    if (grant_data_s && (bus.data_wen == 4'h0)) begin
      state_d = RET_D;
    end else if (grant_inst_s) begin
      state_d = RET_I;
    end else begin
      state_d = IDLE;
    end
  end

  // Return outputs: pass sram_rdata through on the return cycle, else show held copy.
  always_comb begin
    bus.inst_rvalid = 1'b0;
    bus.data_rvalid = 1'b0;
    bus.inst_rdata  = inst_rdata_q;
    bus.data_rdata  = data_rdata_q;
    if (rst) begin
      bus.inst_rdata = 32'h0000_0000;
      bus.data_rdata = 32'h0000_0000;
    end else begin
      case (state_q)
        RET_D: begin
          bus.data_rvalid = 1'b1;
          bus.data_rdata  = bus.sram_rdata;
        end
        RET_I: begin
          bus.inst_rvalid = 1'b1;
          bus.inst_rdata  = bus.sram_rdata;
        end
        default: begin
          bus.inst_rvalid = 1'b0;
          bus.data_rvalid = 1'b0;
        end
      endcase
    end
  end

  // Hold registers keep the last returned word per requester across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rdata_q <= 32'h0000_0000;
      data_rdata_q <= 32'h0000_0000;
    end else begin
      if (state_q == RET_I) begin
        inst_rdata_q <= bus.sram_rdata;
      end
      if (state_q == RET_D) begin
        data_rdata_q <= bus.sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb: scoreboard of expected returns plus directed scenarios.
module tb_sram_arb;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sram_arb_if bus();

  sram_arb #(.STARVE_LIMIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    bit          is_inst;
    logic [31:0] val;
  } ret_t;

  ret_t        sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [31:0] exp_ird     = 32'h0;
  logic [31:0] exp_drd     = 32'h0;
  bit          exp_en;
  logic [3:0]  exp_wen;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  bit          exp_stall;
  bit          ev_i;
  bit          ev_d;
  ret_t        ret;
`ifdef ARB_FAIRNESS_EN
  localparam int LIM = 2;
  int m_cnt = 0;
`endif

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2401_0001;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: read data appears the cycle after an enabled read, garbage otherwise
  always @(posedge clk) begin
    if (bus.sram_en === 1'b1 && bus.sram_wen === 4'h0) bus.sram_rdata <= mem(bus.sram_addr);
    else bus.sram_rdata <= $urandom;
  end

  // Return monitor: pops the scoreboard and checks pulses and held data every cycle
  always @(negedge clk) begin
    ev_i = 1'b0;
    ev_d = 1'b0;
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      ret = sb_q.pop_front();
      ev_i = ret.is_inst;
      ev_d = !ret.is_inst;
      if (ret.is_inst) exp_ird = ret.val;
      else exp_drd = ret.val;
    end
    vectors += 4;
    if (bus.inst_rvalid !== ev_i) begin miscompares++; $display("FAIL mon inst_rvalid cyc %0d got %b want %b", cyc, bus.inst_rvalid, ev_i); end
    if (bus.data_rvalid !== ev_d) begin miscompares++; $display("FAIL mon data_rvalid cyc %0d got %b want %b", cyc, bus.data_rvalid, ev_d); end
    if (bus.inst_rdata !== exp_ird) begin miscompares++; $display("FAIL mon inst_rdata cyc %0d got %h want %h", cyc, bus.inst_rdata, exp_ird); end
    if (bus.data_rdata !== exp_drd) begin miscompares++; $display("FAIL mon data_rdata cyc %0d got %h want %h", cyc, bus.data_rdata, exp_drd); end
  end

  // Drive one cycle of requests, model the grant, queue expected returns, wait to mid-cycle
  task automatic apply(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                       input logic [3:0] dwen, input logic [31:0] daddr, input logic [31:0] dwdata);
    bit gi, gd;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.inst_req = ireq; bus.inst_addr = iaddr;
    bus.data_req = dreq; bus.data_wen = dwen; bus.data_addr = daddr; bus.data_wdata = dwdata;
`ifdef ARB_FAIRNESS_EN
    gi = ireq && (!dreq || m_cnt == LIM);
`else
    gi = ireq && !dreq;
`endif
    gd = dreq && !gi;
    exp_en    = gi || gd;
    exp_wen   = gd ? dwen : 4'h0;
    exp_addr  = gd ? daddr : (gi ? iaddr : 32'h0);
    exp_wdata = gd ? dwdata : 32'h0;
    exp_stall = ireq && !gi;
    if (gd && dwen == 4'h0) sb_q.push_back('{cyc + 1, 1'b0, mem(daddr)});
    if (gi) sb_q.push_back('{cyc + 1, 1'b1, mem(iaddr)});
`ifdef ARB_FAIRNESS_EN
    if (gi || !ireq) m_cnt = 0;
    else if (gd) m_cnt++;
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    apply(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset(input bit busy);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    exp_ird = 32'h0;
    exp_drd = 32'h0;
`ifdef ARB_FAIRNESS_EN
    m_cnt = 0;
`endif
    bus.inst_req = busy; bus.inst_addr = 32'h1234_5678;
    bus.data_req = busy; bus.data_wen = busy ? 4'h3 : 4'h0;
    bus.data_addr = 32'h8765_4321; bus.data_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      do_reset(1'b1);
      vectors += 4;
      if (bus.sram_en !== 1'b0) begin miscompares++; $display("FAIL reset sram_en got %b want 0", bus.sram_en); end
      if (bus.sram_addr !== 32'h0) begin miscompares++; $display("FAIL reset sram_addr got %h want 0", bus.sram_addr); end
      if (bus.sram_wen !== 4'h0 || bus.sram_wdata !== 32'h0) begin miscompares++; $display("FAIL reset sram_wen/wdata got %h/%h want 0/0", bus.sram_wen, bus.sram_wdata); end
      if (bus.stallreq_for_arb !== 1'b0) begin miscompares++; $display("FAIL reset stall got %b want 0", bus.stallreq_for_arb); end
    end
  endtask

  task automatic test_inst_fetch();
    apply(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0);
    vectors += 3;
    if (bus.sram_en !== 1'b1 || bus.sram_wen !== 4'h0) begin miscompares++; $display("FAIL fetch en/wen got %b/%h want 1/0", bus.sram_en, bus.sram_wen); end
    if (bus.sram_addr !== 32'hBFC0_0000) begin miscompares++; $display("FAIL fetch sram_addr got %h want bfc00000", bus.sram_addr); end
    if (bus.stallreq_for_arb !== 1'b0) begin miscompares++; $display("FAIL fetch stall got %b want 0", bus.stallreq_for_arb); end
    idle();
    vectors += 2;
    if (bus.inst_rvalid !== 1'b1 || bus.inst_rdata !== 32'h2401_0001) begin miscompares++; $display("FAIL fetch return got %b/%h want 1/24010001", bus.inst_rvalid, bus.inst_rdata); end
    if (bus.stallreq_for_arb !== 1'b0) begin miscompares++; $display("FAIL fetch stall2 got %b want 0", bus.stallreq_for_arb); end
  endtask

  task automatic test_conflict();
    apply(1'b1, 32'h0000_0100, 1'b1, 4'h0, 32'h8000_1000, 32'h0);
    vectors += 2;
    if (bus.sram_addr !== 32'h8000_1000) begin miscompares++; $display("FAIL conflict sram_addr got %h want 80001000", bus.sram_addr); end
    if (bus.stallreq_for_arb !== 1'b1) begin miscompares++; $display("FAIL conflict stall got %b want 1", bus.stallreq_for_arb); end
    apply(1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h0);
    vectors += 2;
    if (bus.data_rvalid !== 1'b1 || bus.stallreq_for_arb !== 1'b0) begin miscompares++; $display("FAIL conflict N+1 rvalid/stall got %b/%b want 1/0", bus.data_rvalid, bus.stallreq_for_arb); end
    if (bus.sram_addr !== 32'h0000_0100) begin miscompares++; $display("FAIL conflict inst addr got %h want 00000100", bus.sram_addr); end
    idle();
    vectors++;
    if (bus.inst_rvalid !== 1'b1) begin miscompares++; $display("FAIL conflict N+2 inst_rvalid got %b want 1", bus.inst_rvalid); end
  endtask

  task automatic test_data_write();
    apply(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0020, 32'h0);
    idle();
    apply(1'b0, 32'h0, 1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF);
    vectors += 2;
    if (bus.sram_wen !== 4'hF || bus.sram_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL write wen/wdata got %h/%h want f/deadbeef", bus.sram_wen, bus.sram_wdata); end
    if (bus.sram_addr !== 32'h8000_0010 || bus.sram_en !== 1'b1) begin miscompares++; $display("FAIL write addr/en got %h/%b want 80000010/1", bus.sram_addr, bus.sram_en); end
    idle();
    vectors += 2;
    if (bus.data_rvalid !== 1'b0) begin miscompares++; $display("FAIL write data_rvalid got %b want 0", bus.data_rvalid); end
    if (bus.data_rdata !== mem(32'h8000_0020)) begin miscompares++; $display("FAIL write data_rdata got %h want %h", bus.data_rdata, mem(32'h8000_0020)); end
  endtask

  task automatic test_starvation();
    bit want;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 32'h0000_1000, 1'b1, 4'h0, 32'h8000_2000 + 32'(i * 4), 32'h0);
`ifdef ARB_FAIRNESS_EN
      want = (i != 2);
`else
      want = 1'b1;
`endif
      vectors++;
      if (bus.stallreq_for_arb !== want) begin miscompares++; $display("FAIL starve cycle %0d stall got %b want %b", i, bus.stallreq_for_arb, want); end
    end
    idle();
    idle();
  endtask

  task automatic test_reset_outstanding();
    apply(1'b1, 32'h0000_0040, 1'b0, 4'h0, 32'h0, 32'h0);
    do_reset(1'b0);
    vectors++;
    if (bus.inst_rvalid !== 1'b0 || bus.inst_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_out during got %b/%h want 0/0", bus.inst_rvalid, bus.inst_rdata); end
    idle();
    vectors++;
    if (bus.inst_rvalid !== 1'b0 || bus.inst_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_out after got %b/%h want 0/0", bus.inst_rvalid, bus.inst_rdata); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      apply(i < 3, 32'(i * 4), 1'b0, 4'h0, 32'h0, 32'h0);
      if (i > 0) begin
        vectors++;
        if (bus.inst_rvalid !== 1'b1 || bus.inst_rdata !== mem(32'((i - 1) * 4))) begin
          miscompares++;
          $display("FAIL b2b cycle %0d got %b/%h want 1/%h", i, bus.inst_rvalid, bus.inst_rdata, mem(32'((i - 1) * 4)));
        end
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, $urandom & 32'hFFFF_FFFC, $urandom);
      vectors += 5;
      if (bus.sram_en !== exp_en) begin miscompares++; $display("FAIL rand %0d sram_en got %b want %b", i, bus.sram_en, exp_en); end
      if (bus.sram_wen !== exp_wen) begin miscompares++; $display("FAIL rand %0d sram_wen got %h want %h", i, bus.sram_wen, exp_wen); end
      if (bus.sram_addr !== exp_addr) begin miscompares++; $display("FAIL rand %0d sram_addr got %h want %h", i, bus.sram_addr, exp_addr); end
      if (bus.sram_wdata !== exp_wdata) begin miscompares++; $display("FAIL rand %0d sram_wdata got %h want %h", i, bus.sram_wdata, exp_wdata); end
      if (bus.stallreq_for_arb !== exp_stall) begin miscompares++; $display("FAIL rand %0d stall got %b want %b", i, bus.stallreq_for_arb, exp_stall); end
    end
    idle();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    bus.inst_req = 1'b0; bus.inst_addr = 32'h0;
    bus.data_req = 1'b0; bus.data_wen = 4'h0; bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
    test_reset();
    test_inst_fetch();
    test_conflict();
    test_data_write();
    test_starvation();
    test_reset_outstanding();
    test_back_to_back();
    test_random();
    vectors++;
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL drain pending returns got %0d want 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 2: maximum consecutive data grants while a fetch waits (used only with ARB_FAIRNESS_EN).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inst_req  input  1  instruction fetch request.
REQ-005 inst_addr  input  32  fetch address.
REQ-006 data_req  input  1  data access request.
REQ-007 data_wen  input  4  byte write enables; 0 = read.
REQ-008 data_addr  input  32  data address.
REQ-009 data_wdata  input  32  write data.
REQ-010 sram_en  output  1  unified SRAM enable.
REQ-011 sram_wen  output  4  unified SRAM byte write enables.
REQ-012 sram_addr  output  32  unified SRAM address.
REQ-013 sram_wdata  output  32  unified SRAM write data.
REQ-014 sram_rdata  input  32  SRAM read data, valid one cycle after an enabled read.
REQ-015 inst_rdata  output  32  held fetch data.
REQ-016 inst_rvalid  output  1  one-cycle pulse: inst_rdata updated this cycle.
REQ-017 data_rdata  output  32  held load data.
REQ-018 data_rvalid  output  1  one-cycle pulse: data_rdata updated this cycle.
REQ-019 stallreq_for_arb  output  1  fetch denied this cycle; feeds the stall controller.

Function
REQ-020 Grant is combinational per cycle: data_req alone -> data; inst_req alone -> inst; both -> data, unless fairness override (REQ-031) applies.
REQ-021 Granted requester's address/wen/wdata drive the sram_* outputs in the same cycle; inst grant drives sram_wen = 0 and sram_wdata = 0.
REQ-022 No grant -> sram_en = 0, sram_wen = 0, sram_addr = 0, sram_wdata = 0.
REQ-023 A registered return-state FSM has three states: IDLE (no read outstanding), RET_D (data read granted last cycle), RET_I (inst read granted last cycle).
REQ-024 Next state: data read granted -> RET_D; inst granted -> RET_I; otherwise (including data write) -> IDLE; valid from any state.
REQ-025 In RET_D: data_rdata <= sram_rdata and data_rvalid = 1 for that cycle; in RET_I: inst_rdata <= sram_rdata and inst_rvalid = 1.
REQ-026 Read latency: request granted in cycle N -> rvalid and rdata in cycle N+1.
REQ-027 inst_rdata and data_rdata hold their last values until the next return for that requester, surviving pipeline stalls.
REQ-028 Data writes produce no rvalid pulse.
REQ-029 stallreq_for_arb = inst_req AND NOT inst granted; asserted in the same cycle as the conflict.
REQ-030 A new grant may issue in the same cycle as a return (back-to-back, one access per cycle, no bubbles).

Configuration
REQ-031 With macro ARB_FAIRNESS_EN defined:
- A starvation counter increments on each cycle where data is granted while inst_req = 1.
- It clears on any inst grant or when inst_req = 0.
- When the counter equals STARVE_LIMIT and both requests are present, inst is granted; data is denied and held by its requester.
REQ-032 Without ARB_FAIRNESS_EN: strict data priority; no counter is instantiated; fetch is denied for as long as data_req stays high.

Reset
REQ-033 While rst = 1:
- FSM -> IDLE.
- inst_rdata = 0, data_rdata = 0, inst_rvalid = 0, data_rvalid = 0.
- Starvation counter = 0.
- All sram_* outputs and stallreq_for_arb = 0 regardless of requests.
REQ-034 Reset asserted with a read outstanding discards the return; no rvalid pulses in the cycle after rst deasserts unless a new grant occurred.

Verification
REQ-035 inst_req=1, inst_addr=0xBFC00000 alone, sram_rdata=0x24010001 next cycle -> sram_en=1, sram_wen=0 in cycle N; inst_rvalid=1, inst_rdata=0x24010001 in N+1; stallreq_for_arb=0 throughout.
REQ-036 Simultaneous inst_req and data_req read to 0x80001000 -> sram_addr=0x80001000, stallreq_for_arb=1 in N; data_rvalid=1 in N+1; inst granted in N+1 with inst_rvalid=1 in N+2.
REQ-037 Data write, data_wen=0xF, wdata=0xDEADBEEF, addr=0x80000010 -> sram_wen=0xF, sram_wdata=0xDEADBEEF; no rvalid in next cycle; data_rdata unchanged.
REQ-038 Four consecutive data reads with inst_req held high -> without macro: stallreq_for_arb=1 for all 4 cycles; with ARB_FAIRNESS_EN, STARVE_LIMIT=2: third cycle grants inst, stallreq_for_arb=0 that cycle.
REQ-039 rst=1 in the cycle after an inst grant -> no inst_rvalid; inst_rdata=0; FSM in IDLE after reset release.
REQ-040 Back-to-back inst reads at 0x0, 0x4, 0x8 -> inst_rvalid high for 3 consecutive cycles; each inst_rdata value matches the sram_rdata of the corresponding cycle.
